apb_master_bridge: RTL and testbench

//  APB requester driving the shared peripheral bus that the GPIO and UART completers sit on.

---
 rtl/apb_master_bridge.sv | 142 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB requester bridging a valid/ready command/response port onto the shared GPIO/UART bus.
// Runs one SETUP/ACCESS sequence per command, with an ACCESS timeout for hung completers.
module apb_master_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [3:0]  GPIO_REGION = 4'h1,
  parameter logic [3:0]  UART_REGION = 4'h2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] pAdd,
  output logic [31:0] pwData,
  output logic [1:0]  psel,
  output logic        pen,
  output logic        pwr,
  input  logic [31:0] prdata,
  input  logic        pready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  // Counter value on the last ACCESS cycle allowed before the transfer is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e      state_q;
  logic        cmd_ready_q;
  logic [31:0] padd_q;
  logic [31:0] pwdata_q;
  logic [1:0]  psel_q;
  logic        pen_q;
  logic        pwr_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic [1:0]  sel_d;

  assign cnt_d = cnt_q + 8'd1;

  always_comb begin
    sel_d = 2'b00;
    if (cmd_addr[31:28] == GPIO_REGION)      sel_d = 2'b01;
    else if (cmd_addr[31:28] == UART_REGION) sel_d = 2'b10;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      padd_q      <= '0;
      pwdata_q    <= '0;
      psel_q      <= 2'b00;
      pen_q       <= 1'b0;
      pwr_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            padd_q      <= cmd_addr;
            pwdata_q    <= cmd_wdata;
            pwr_q       <= cmd_wr;
            cmd_ready_q <= 1'b0;
            if (sel_d != 2'b00) begin
              psel_q  <= sel_d;
              state_q <= S_SETUP;
            end else begin
              // Unmapped address: answer with an error and leave the bus idle.
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          pen_q   <= 1'b1;
          state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            psel_q      <= 2'b00;
            pen_q       <= 1'b0;
            rsp_rdata_q <= pwr_q ? 32'h0 : prdata;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_q == TO_LAST) begin
              psel_q      <= 2'b00;
              pen_q       <= 1'b0;
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign pAdd      = padd_q;
  assign pwData    = pwdata_q;
  assign psel      = psel_q;
  assign pen       = pen_q;
  assign pwr       = pwr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: scenario tasks plus a response scoreboard queue.
// Built with a 4-cycle ACCESS timeout so the timeout path is reachable quickly.
module tb_apb_master_bridge;

  localparam int unsigned TO = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] pAdd;
  logic [31:0] pwData;
  logic [1:0]  psel;
  logic        pen;
  logic        pwr;
  logic [31:0] prdata;
  logic        pready;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .TIMEOUT_CYC(TO),
    .GPIO_REGION(4'h1),
    .UART_REGION(4'h2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .pAdd(pAdd),
    .pwData(pwData),
    .psel(psel),
    .pen(pen),
    .pwr(pwr),
    .prdata(prdata),
    .pready(pready)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
  endtask

  // Scoreboard consumer: wait (bounded) for a response, compare it, complete the handshake.
  task automatic drain_rsp(input string name);
    exp_t exp;
    int   n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_rsp_timeout got rsp_valid=%b want 1 within 50 cycles", name, rsp_valid);
      return;
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected_rsp got a response want none queued", name);
    end else begin
      exp = sb_q.pop_front();
      checks++;
      if (rsp_rdata !== exp.rdata) begin errors++; $display("FAIL %s_rdata got %h want %h", name, rsp_rdata, exp.rdata); end
      checks++;
      if (rsp_err !== exp.err) begin errors++; $display("FAIL %s_err got %b want %b", name, rsp_err, exp.err); end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s_rsp_drop got rsp_valid=%b want 0", name, rsp_valid); end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s_idle got cmd_ready=%b want 1", name, cmd_ready); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (psel !== 2'b00) begin errors++; $display("FAIL rst_psel got %b want 00", psel); end
    checks++; if (pen !== 1'b0) begin errors++; $display("FAIL rst_pen got %b want 0", pen); end
    checks++; if (pwr !== 1'b0) begin errors++; $display("FAIL rst_pwr got %b want 0", pwr); end
    checks++; if (pAdd !== 32'h0) begin errors++; $display("FAIL rst_paddr got %h want 0", pAdd); end
    checks++; if (pwData !== 32'h0) begin errors++; $display("FAIL rst_pwdata got %h want 0", pwData); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b want 0", rsp_err); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
  endtask

  // Zero-wait write to UART: SETUP, one ACCESS cycle, response in the third cycle.
  task automatic test_write;
    prdata = 32'hFFFF_FFFF;
    drive_cmd(1'b1, 32'h2000_0004, 32'hA5A5_0001);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_cmd_ready got %b want 1", cmd_ready); end
    sb_q.push_back('{rdata: 32'h0, err: 1'b0});
    tick();
    cmd_valid = 1'b0;
    pready    = 1'b1;
    checks++; if (psel !== 2'b10) begin errors++; $display("FAIL wr_setup_psel got %b want 10", psel); end
    checks++; if (pen !== 1'b0) begin errors++; $display("FAIL wr_setup_pen got %b want 0", pen); end
    checks++; if (pwr !== 1'b1) begin errors++; $display("FAIL wr_setup_pwr got %b want 1", pwr); end
    checks++; if (pAdd !== 32'h2000_0004) begin errors++; $display("FAIL wr_paddr got %h want 20000004", pAdd); end
    checks++; if (pwData !== 32'hA5A5_0001) begin errors++; $display("FAIL wr_pwdata got %h want a5a50001", pwData); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_busy_ready got %b want 0", cmd_ready); end
    tick();
    checks++; if (pen !== 1'b1) begin errors++; $display("FAIL wr_access_pen got %b want 1", pen); end
    checks++; if (psel !== 2'b10) begin errors++; $display("FAIL wr_access_psel got %b want 10", psel); end
    tick();
    pready = 1'b0;
    checks++; if (pen !== 1'b0) begin errors++; $display("FAIL wr_resp_pen got %b want 0", pen); end
    checks++; if (psel !== 2'b00) begin errors++; $display("FAIL wr_resp_psel got %b want 00", psel); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_latency got rsp_valid=%b want 1", rsp_valid); end
    drain_rsp("wr");
  endtask

  // GPIO read with three wait states; the ready cycle coincides with the last timeout slot.
  task automatic test_read_wait;
    int pen_cyc = 0;
    int n = 0;
    prdata = 32'hDEAD_BEEF;
    drive_cmd(1'b0, 32'h1000_0000, 32'h0);
    sb_q.push_back('{rdata: 32'h0000_00FF, err: 1'b0});
    tick();
    cmd_valid = 1'b0;
    checks++; if (psel !== 2'b01) begin errors++; $display("FAIL rd_setup_psel got %b want 01", psel); end
    tick();
    while (pen === 1'b1 && n < 20) begin
      pen_cyc++;
      n++;
      checks++;
      if (psel !== 2'b01 || pAdd !== 32'h1000_0000 || pwr !== 1'b0) begin
        errors++;
        $display("FAIL rd_stable got psel=%b addr=%h pwr=%b want 01/10000000/0", psel, pAdd, pwr);
      end
      if (pen_cyc == 4) begin
        pready = 1'b1;
        prdata = 32'h0000_00FF;
      end
      tick();
    end
    pready = 1'b0;
    prdata = 32'hDEAD_BEEF;
    checks++; if (pen_cyc != 4) begin errors++; $display("FAIL rd_pen_cycles got %0d want 4", pen_cyc); end
    drain_rsp("rd");
  endtask

  task automatic test_decode_err;
    drive_cmd(1'b0, 32'h3000_0000, 32'h0);
    sb_q.push_back('{rdata: 32'h0, err: 1'b1});
    tick();
    cmd_valid = 1'b0;
    checks++; if (psel !== 2'b00) begin errors++; $display("FAIL dec_psel got %b want 00", psel); end
    checks++; if (pen !== 1'b0) begin errors++; $display("FAIL dec_pen got %b want 0", pen); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL dec_rsp_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL dec_rsp_err got %b want 1", rsp_err); end
    checks++; if (pAdd !== 32'h3000_0000) begin errors++; $display("FAIL dec_paddr got %h want 30000000", pAdd); end
    drain_rsp("dec");
  endtask

  task automatic test_timeout;
    int pen_cyc = 0;
    int n = 0;
    pready = 1'b0;
    prdata = 32'h1234_5678;
    drive_cmd(1'b0, 32'h1000_0010, 32'h0);
    sb_q.push_back('{rdata: 32'h0, err: 1'b1});
    tick();
    cmd_valid = 1'b0;
    tick();
    while (pen === 1'b1 && n < 20) begin
      pen_cyc++;
      n++;
      tick();
    end
    checks++; if (pen_cyc != TO) begin errors++; $display("FAIL to_pen_cycles got %0d want %0d", pen_cyc, TO); end
    checks++; if (psel !== 2'b00) begin errors++; $display("FAIL to_psel got %b want 00", psel); end
    drain_rsp("to");
  endtask

  // Response held off for 5 cycles while new commands are offered; none may be taken.
  task automatic test_rsp_backpressure;
    exp_t exp;
    prdata = 32'hCAFE_F00D;
    pready = 1'b1;
    drive_cmd(1'b0, 32'h2000_0008, 32'h0);
    sb_q.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    pready = 1'b0;
    prdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d got v=%b d=%h e=%b want 1/cafef00d/0", i, rsp_valid, rsp_rdata, rsp_err);
      end
      checks++;
      if (cmd_ready !== 1'b0 || pAdd !== 32'h2000_0008 || psel !== 2'b00) begin
        errors++;
        $display("FAIL bp_no_accept_%0d got ready=%b addr=%h psel=%b want 0/20000008/00", i, cmd_ready, pAdd, psel);
      end
      if (i == 1) drive_cmd(1'b1, 32'h1000_00F0, 32'h0000_0077);
      if (i == 2) cmd_valid = 1'b0;
      if (i == 3) drive_cmd(1'b1, 32'h1000_0004, 32'h0000_0055);
      tick();
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL bp_unexpected_rsp got a response want none queued");
    end else begin
      exp = sb_q.pop_front();
      checks++;
      if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin
        errors++;
        $display("FAIL bp_rsp got %h/%b want %h/%b", rsp_rdata, rsp_err, exp.rdata, exp.err);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_rsp_drop got %b want 0", rsp_valid); end
    checks++; if (psel !== 2'b00) begin errors++; $display("FAIL bp_gap_psel got %b want 00", psel); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b want 1", cmd_ready); end
    sb_q.push_back('{rdata: 32'h0, err: 1'b0});
    pready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++; if (psel !== 2'b01) begin errors++; $display("FAIL bp_second_psel got %b want 01", psel); end
    checks++; if (pAdd !== 32'h1000_0004) begin errors++; $display("FAIL bp_second_addr got %h want 10000004", pAdd); end
    checks++; if (pwData !== 32'h0000_0055) begin errors++; $display("FAIL bp_second_wdata got %h want 00000055", pwData); end
    tick();
    tick();
    pready = 1'b0;
    drain_rsp("bp2");
  endtask

  task automatic test_reset_mid;
    pready = 1'b0;
    drive_cmd(1'b0, 32'h1000_0020, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checks++; if (pen !== 1'b1) begin errors++; $display("FAIL rm_in_access got pen=%b want 1", pen); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (psel !== 2'b00) begin errors++; $display("FAIL rm_psel got %b want 00", psel); end
    checks++; if (pen !== 1'b0) begin errors++; $display("FAIL rm_pen got %b want 0", pen); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_cmd_ready got %b want 1", cmd_ready); end
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || psel !== 2'b00) begin
        errors++;
        $display("FAIL rm_no_rsp_%0d got rsp_valid=%b psel=%b want 0/00", i, rsp_valid, psel);
      end
    end
    pready = 1'b0;
  endtask

  // Commands offered as soon as cmd_ready rises; responses taken immediately.
  task automatic test_back_to_back;
    logic        t_wr[4]    = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_addr[4]  = '{32'h2000_0010, 32'h1000_0014, 32'hF000_0000, 32'h2000_001C};
    logic [31:0] t_wdata[4] = '{32'h1111_2222, 32'h0, 32'h0, 32'h0};
    logic [31:0] t_prd[4]   = '{32'hAAAA_0000, 32'h0BAD_CAFE, 32'h0000_9999, 32'h7654_3210};
    logic [31:0] t_exp[4]   = '{32'h0, 32'h0BAD_CAFE, 32'h0, 32'h7654_3210};
    logic        t_err[4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
    exp_t exp;
    int idx = 0;
    int got = 0;
    int cyc = 0;
    pready    = 1'b1;
    rsp_ready = 1'b1;
    while ((idx < 4 || got < 4) && cyc < 100) begin
      if (rsp_valid === 1'b1) begin
        checks++;
        if (psel !== 2'b00) begin errors++; $display("FAIL b2b_gap_%0d got psel=%b want 00", got, psel); end
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected_rsp_%0d got a response want none queued", got);
        end else begin
          exp = sb_q.pop_front();
          checks++;
          if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin
            errors++;
            $display("FAIL b2b_rsp_%0d got %h/%b want %h/%b", got, rsp_rdata, rsp_err, exp.rdata, exp.err);
          end
        end
        got++;
      end
      if (cmd_ready === 1'b1 && idx < 4) begin
        drive_cmd(t_wr[idx], t_addr[idx], t_wdata[idx]);
        prdata = t_prd[idx];
        sb_q.push_back('{rdata: t_exp[idx], err: t_err[idx]});
        idx++;
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    pready    = 1'b0;
    checks++; if (got != 4) begin errors++; $display("FAIL b2b_count got %0d want 4 responses", got); end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    prdata    = 32'h0;
    pready    = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_decode_err();
    test_timeout();
    test_rsp_backpressure();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d pending want 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
